core_ctrl: RTL
==============

# core_ctrl

Sequencer that sits directly upstream of the ALU in the tiny processor. It fetches instruction bytes from an external byte memory over a request/valid handshake and decodes them into ALU select and operand signals. It holds the accumulator, program counter and an 8-entry register file, and writes the ALU result back into the accumulator. It also resolves `bnez` branches and register stores, which bypass the ALU writeback.

## Interface
Parameters:
- `NREGS`, 8: register file depth; fixed at 8 because the index field is 3 bits.
- `PC_W`, 8: program counter width, equal to the memory address width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `run`  in  1: 1 = execute, 0 = halt at the next instruction boundary.
- `mem_req`  out  1: fetch request.
- `mem_addr`  out  PC_W: fetch address; stable while `mem_req`=1.
- `mem_rdata`  in  8: fetched byte; sampled when `mem_valid`=1.
- `mem_valid`  in  1: data valid; one-cycle pulse, may coincide with the first `mem_req` cycle.
- `unit_sel_out`  out  3: to ALU `unit_sel_in`.
- `op_sel_out`  out  1: to ALU `op_sel_in`.
- `acc_out`  out  8: accumulator, to ALU `acc_in`.
- `src_out`  out  8: operand, to ALU `src_in`.
- `alu_res_in`  in  8: from ALU `alu_res_out`.
- `halted`  out  1: 1 when parked in FETCH with `run`=0.
- `dbg_r7`  out  8: register r7, exposed as the output port.

## Operation
Instruction byte format:
- [7:5] unit: 000 add/sub, 001 mul, 010 shift, 011 move, 100 or, 101 xor, 110 and, 111 special.
- [4] op_sel.
- [3] imm: 1 = operand is the next memory byte; 0 = operand is r[idx].
- [2:0] idx.

Decode:
- Units 000–110: `acc <= alu_res_in` in EXEC.
- Unit 111, op_sel=0 (BNEZ): the target is always fetched as the next byte and the imm bit is ignored. If `acc != 0`, `pc <= target`; otherwise `pc <= pc+2`. ALU is driven with unit 111; acc is unchanged.
- Unit 111, op_sel=1 (STORE): `r[idx] <= acc` and `pc <= pc+1`. No operand fetch. acc is unchanged.
- PC advance for all other instructions: +1 for register operand, +2 for immediate.
- PC arithmetic is modulo 2^PC_W: 0xFF+1 = 0x00, and 0xFF+2 = 0x01.
- The operand fetch address is pc+1, which also wraps.
- `src_out` is the captured immediate byte when imm=1 (or BNEZ), else r[idx].

State machine (`st`):
- FETCH: `mem_req`=run, `mem_addr`=pc.
  - `mem_valid` & run: capture `ir`; go to OPERAND if imm=1 or BNEZ, else EXEC.
  - run=0: stay, `halted`=1.
- OPERAND: `mem_req`=1, `mem_addr`=pc+1. On `mem_valid`, capture `opnd` and go to EXEC.
- EXEC: one cycle. Perform the writeback or branch, update pc, return to FETCH.

Boundary rules:
- `mem_valid` while `mem_req`=0 is ignored.
- Dropping `run` mid-instruction does not abort it: OPERAND and EXEC complete, then the block parks in FETCH.
- Asynchronous `rst` at any point immediately forces the reset state. Any in-flight fetch is abandoned, and a late `mem_valid` after reset is ignored because `mem_req`=0 during reset.
- STORE to r7 updates `dbg_r7` on the EXEC edge.

## Timing
Reset values:
- pc=0, acc=0, all regs=0, ir=0, opnd=0, st=FETCH.
- `mem_req`=0 while `rst`=1, `halted`=0 while `rst`=1.
- `unit_sel_out`=0, `op_sel_out`=0, `src_out`=0, `acc_out`=0, `dbg_r7`=0.

Handshake and latency:
- `mem_req` rises in the first cycle after reset deassertion with run=1.
- With zero-wait memory (valid in the same cycle as req): register-operand instructions take 2 cycles (FETCH, EXEC); immediate and BNEZ take 3 cycles.
- Each memory wait cycle adds 1.

ALU interface:
- ALU outputs are combinational from `ir`, `opnd`, `acc` and regs, and are valid throughout EXEC.
- `alu_res_in` is sampled at the EXEC rising edge.
- Outputs are driven from registered state only; there is no combinational path from memory inputs to `mem_req` or `mem_addr`.

## Structure
Package `core_pkg`:
- Unit codes UNIT_ADD..UNIT_SPECIAL.
- State encoding FETCH/OPERAND/EXEC.
- Instruction field positions.
- Shared with the ALU decode.

Sub-module `reg_file`:
- 8×8 registers, one async read port (idx), one write port (we, idx, data).
- Async reset to 0; r7 exported.

## Test plan
- Reset, then `LDI 0x05` (byte 0x78, then 0x05) with zero-wait memory: acc=0x05 after 3 cycles, pc=2.
- `LDI 0x05; ADDI 0x03; STORE r2` (bytes 0x78 05 08 03 F2): acc=0x08, r2=0x08, pc=5 after 8 cycles.
- acc=1 at pc=0xFE, BNEZ (0xE8, target 0x10): pc=0x10. With acc=0, the same BNEZ gives pc=0x00 (wrap).
- 2-cycle memory wait states with run dropped during OPERAND of an immediate: the instruction completes, the block parks in FETCH, `halted`=1 and `mem_req`=0.
- `rst` pulse during OPERAND, then a stray `mem_valid` with 0xFF: all state returns to reset values, the stray byte is ignored, and the next fetch is from addr 0.
- `STORE r7` after `LDI 0xA5`: `dbg_r7`=0xA5 at the EXEC edge.

Source files
------------

// File: rtl/core_pkg.sv
// Purpose : shared decode constants for the tiny processor (core_ctrl and ALU decode).
// Latency : n/a (types, constants and one pure function).
// Backpr. : n/a.
package core_pkg;

  // ALU unit codes carried in instruction bits [7:5].
  localparam logic [2:0] UNIT_ADD     = 3'd0;
  localparam logic [2:0] UNIT_MUL     = 3'd1;
  localparam logic [2:0] UNIT_SHIFT   = 3'd2;
  localparam logic [2:0] UNIT_MOVE    = 3'd3;
  localparam logic [2:0] UNIT_OR      = 3'd4;
  localparam logic [2:0] UNIT_XOR     = 3'd5;
  localparam logic [2:0] UNIT_AND     = 3'd6;
  localparam logic [2:0] UNIT_SPECIAL = 3'd7;

  // Sequencer states.
  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_OPERAND = 2'd1;
  localparam logic [1:0] ST_EXEC    = 2'd2;

  // Instruction field positions (mirrored by the packed struct below).
  localparam int INSTR_UNIT_MSB = 7;
  localparam int INSTR_UNIT_LSB = 5;
  localparam int INSTR_OPSEL    = 4;
  localparam int INSTR_IMM      = 3;
  localparam int INSTR_IDX_MSB  = 2;
  localparam int INSTR_IDX_LSB  = 0;

  typedef struct packed {
    logic [2:0] unit;
    logic       op_sel;
    logic       imm;
    logic [2:0] idx;
  } instr_t;

  // BNEZ always pulls a target byte; STORE never does, whatever its imm bit.
  function automatic logic needs_operand(input instr_t i);
    if (i.unit == UNIT_SPECIAL) begin
      return !i.op_sel;
    end
    return i.imm;
  endfunction

endpackage

// File: rtl/core_ctrl_if.sv
// Purpose : byte-memory fetch channel between core_ctrl (master) and instruction memory (slave).
// Latency : n/a (wires only).
// Backpr. : master holds mem_req/mem_addr until a one-cycle mem_valid pulse from the slave.
// Ports   : mem_req, mem_addr (master->slave); mem_rdata, mem_valid (slave->master).
interface core_ctrl_if #(
  parameter int PC_W = 8
);
  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic [7:0]      mem_rdata;
  logic            mem_valid;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_valid
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_valid
  );
endinterface

// File: rtl/core_ctrl_reg_file.sv
// Purpose : 8x8 general register file, async read, single synchronous write, r7 exported.
// Latency : read combinational; write visible the cycle after the we edge.
// Backpr. : none, write always accepted.
// Ports   : clk/rst; we, widx, wdat write port; ridx/rdat read port; r7 debug tap.
module reg_file #(
  parameter int NREGS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [2:0] widx,
  input  logic [7:0] wdat,
  input  logic [2:0] ridx,
  output logic [7:0] rdat,
  output logic [7:0] r7
);

  logic [7:0] regs_q [NREGS];
  logic [7:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[widx] = wdat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdat = regs_q[ridx];
  assign r7   = regs_q[NREGS-1];

endmodule

// File: rtl/core_ctrl.sv
// Purpose : fetch/decode sequencer feeding the ALU; owns pc, acc, ir, operand and register file.
// Latency : 2 cycles for register ops, 3 for immediate/BNEZ, +1 per memory wait cycle.
// Backpr. : stalls in FETCH/OPERAND until mem_valid; run=0 parks at the next instruction boundary.
// Ports   : clk, rst, run; mem (fetch channel, master); unit_sel_out, op_sel_out, acc_out,
//           src_out to the ALU and alu_res_in back; halted status; dbg_r7 register tap.
module core_ctrl
  import core_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int PC_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  core_ctrl_if.master        mem,
  output logic [2:0]         unit_sel_out,
  output logic               op_sel_out,
  output logic [7:0]         acc_out,
  output logic [7:0]         src_out,
  input  logic [7:0]         alu_res_in,
  output logic               halted,
  output logic [7:0]         dbg_r7
);

  logic [1:0]      st_q,   st_d;
  logic [PC_W-1:0] pc_q,   pc_d;
  logic [7:0]      acc_q,  acc_d;
  instr_t          ir_q,   ir_d;
  logic [7:0]      opnd_q, opnd_d;

  logic [PC_W-1:0] pc_p1;
  logic [PC_W-1:0] pc_p2;
  instr_t          fetch_ir;
  logic            is_bnez;
  logic            rf_we;
  logic [7:0]      rf_rdat;

  // pc arithmetic wraps naturally at 2^PC_W.
  assign pc_p1    = pc_q + PC_W'(1);
  assign pc_p2    = pc_q + PC_W'(2);
  assign fetch_ir = instr_t'(mem.mem_rdata);
  assign is_bnez  = (ir_q.unit == UNIT_SPECIAL) && !ir_q.op_sel;

  always_comb begin
    st_d   = st_q;
    pc_d   = pc_q;
    acc_d  = acc_q;
    ir_d   = ir_q;
    opnd_d = opnd_q;
    rf_we  = 1'b0;
    case (st_q)
      ST_FETCH: begin
        // mem_req equals run here, so gating on run also drops valids with no request.
        if (run && mem.mem_valid) begin
          ir_d = fetch_ir;
          st_d = needs_operand(fetch_ir) ? ST_OPERAND : ST_EXEC;
        end
      end
      ST_OPERAND: begin
        if (mem.mem_valid) begin
          opnd_d = mem.mem_rdata;
          st_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        st_d = ST_FETCH;
        if (ir_q.unit != UNIT_SPECIAL) begin
          acc_d = alu_res_in;
          pc_d  = ir_q.imm ? pc_p2 : pc_p1;
        end else if (ir_q.op_sel) begin
          // STORE: register write bypasses the ALU, acc untouched.
          rf_we = 1'b1;
          pc_d  = pc_p1;
        end else begin
          pc_d = (acc_q != '0) ? PC_W'(opnd_q) : pc_p2;
        end
      end
      default: st_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= ST_FETCH;
      pc_q   <= '0;
      acc_q  <= '0;
      ir_q   <= '0;
      opnd_q <= '0;
    end else begin
      st_q   <= st_d;
      pc_q   <= pc_d;
      acc_q  <= acc_d;
      ir_q   <= ir_d;
      opnd_q <= opnd_d;
    end
  end

  reg_file #(.NREGS(NREGS)) u_rf (
    .clk  (clk),
    .rst  (rst),
    .we   (rf_we),
    .widx (ir_q.idx),
    .wdat (acc_q),
    .ridx (ir_q.idx),
    .rdat (rf_rdat),
    .r7   (dbg_r7)
  );

  // Request depends only on state, run and rst; never on the memory's own outputs.
  assign mem.mem_req  = !rst && ((st_q == ST_OPERAND) || ((st_q == ST_FETCH) && run));
  assign mem.mem_addr = (st_q == ST_OPERAND) ? pc_p1 : pc_q;
  assign halted       = !rst && (st_q == ST_FETCH) && !run;

  assign unit_sel_out = ir_q.unit;
  assign op_sel_out   = ir_q.op_sel;
  assign acc_out      = acc_q;
  assign src_out      = (ir_q.imm || is_bnez) ? opnd_q : rf_rdat;

endmodule
